// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Produces one quotient bit per clock; result packs {remainder, quotient}.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_remNext;
  logic [WIDTH-1:0] w_qNext;
  logic             w_lastStep;

  // Restoring step: a negative trial (MSB set) keeps the shifted remainder.
  always_comb begin
    w_shift   = {r_rem, r_q[WIDTH-1]};
    w_trial   = w_shift - {1'b0, r_div};
    w_remNext = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    w_qNext   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
  end

  assign w_lastStep = (r_cnt == CW'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (w_lastStep) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and output registers; outputs load only on the edge that enters DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_div <= divisor;
            r_rem <= '0;
            r_q   <= dividend;
            r_cnt <= CW'(WIDTH);
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          r_rem <= w_remNext;
          r_q   <= w_qNext;
          r_cnt <= r_cnt - CW'(1);
          if (w_lastStep) begin
            quotient    <= w_qNext;
            remainder   <= w_remNext;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = {remainder, quotient};
  assign busy   = (r_state == RUN);
  assign done   = r_done;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected {remainder, quotient},
// monitor pops and compares whenever done pulses.
module tb_seq_divider;

  localparam int WIDTH = 4;

  logic             clock;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [2*WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  typedef struct {
    int q;
    int r;
    int dbz;
  } expect_t;

  expect_t scoreQ[$];
  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .result(result),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Reference: plain integer division, all-ones quotient for a zero divisor.
  function automatic expect_t model(input int a, input int b);
    expect_t e;
    if (b == 0) begin
      e.q = (1 << WIDTH) - 1;
      e.r = a;
      e.dbz = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        expect_t e;
        e = scoreQ.pop_front();
        checkOutput("quotient", int'(quotient), e.q);
        checkOutput("remainder", int'(remainder), e.r);
        checkOutput("result", int'(result), (e.r << WIDTH) | e.q);
        checkOutput("div_by_zero", int'(div_by_zero), e.dbz);
      end
    end
  end

  // Issues one division; disturb >= 0 pulses a bogus start that many edges after acceptance.
  task automatic applyStimulus(input int a, input int b, input int disturb);
    int edges;
    int busyCount;
    @(negedge clock);
    start    = 1'b1;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    @(posedge clock);
    #1;
    scoreQ.push_back(model(a, b));
    edges = 0;
    busyCount = int'(busy);
    start = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
    while (!done) begin
      if (edges == disturb) begin
        start    = 1'b1;
        dividend = WIDTH'(6);
        divisor  = WIDTH'(2);
      end else begin
        start    = 1'b0;
        dividend = WIDTH'($urandom);
      end
      @(posedge clock);
      #1;
      edges++;
      if (!done) busyCount += int'(busy);
      if (edges > 20) begin
        checkOutput("done_timeout", edges, (b == 0) ? 1 : WIDTH + 1);
        break;
      end
    end
    start = 1'b0;
    if (done) begin
      checkOutput("latency", edges, (b == 0) ? 1 : WIDTH + 1);
      checkOutput("busy_cycles", busyCount, (b == 0) ? 0 : WIDTH);
      @(posedge clock);
      #1;
      checkOutput("done_one_cycle", int'(done), 0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_quotient"}, int'(quotient), 0);
    checkOutput({tag, "_remainder"}, int'(remainder), 0);
    checkOutput({tag, "_result"}, int'(result), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_dbz"}, int'(div_by_zero), 0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(13, 3, -1);
    applyStimulus(15, 1, -1);
    applyStimulus(3, 7, -1);
    applyStimulus(5, 0, -1);
    applyStimulus(9, 2, -1);
    applyStimulus(13, 3, 1);
    repeat (8) @(posedge clock);

    // Abort 14/3 in its second RUN cycle with an asynchronous reset.
    @(negedge clock);
    start = 1'b1;
    dividend = WIDTH'(14);
    divisor  = WIDTH'(3);
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    checkOutput("post_abort_done", int'(done), 0);
    applyStimulus(14, 3, -1);

    for (int a = 0; a < (1 << WIDTH); a++)
      for (int b = 0; b < (1 << WIDTH); b++)
        applyStimulus(a, b, -1);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      applyStimulus(int'($urandom_range(0, (1 << WIDTH) - 1)),
                    int'($urandom_range(0, (1 << WIDTH) - 1)), -1);
    end

    repeat (4) @(posedge clock);
    checkOutput("scoreboard_drained", scoreQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
